axi_lite_slave_regs: RTL and testbench
======================================

Name: axi_lite_slave_regs

Overview:
AXI4-Lite slave that terminates the AW/W/B/AR/R channels driven by the team's AXI master. It backs the channels with a bank of NUM_REGS 32-bit memory-mapped registers. Writes honour WSTRB byte lanes, out-of-range accesses return SLVERR, and register contents plus per-register write strobes are exported to user logic. Read and write paths are independent and may run concurrently.

Parameters:
NUM_REGS, 8, number of 32-bit registers (power of two, 2..256)
ADDR_LSB, 2, byte-offset bits ignored in address decode (word aligned)

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  synchronous, active-high reset
AWVALID  in  1  write-address valid
AWREADY  out  1  write-address ready
AWADDR  in  32  write byte address
WVALID  in  1  write-data valid
WREADY  out  1  write-data ready
WDATA  in  32  write data
WSTRB  in  4  byte-lane enables, bit n -> WDATA[8n+7:8n]
BVALID  out  1  write-response valid
BREADY  in  1  write-response ready
BRESP  out  2  00 OKAY, 10 SLVERR
ARVALID  in  1  read-address valid
ARREADY  out  1  read-address ready
ARADDR  in  32  read byte address
RVALID  out  1  read-data valid
RREADY  in  1  read-data ready
RDATA  out  32  read data
RRESP  out  2  00 OKAY, 10 SLVERR
reg_out  out  NUM_REGS*32  flattened register contents; reg k at [32k+31:32k]
wr_pulse  out  NUM_REGS  one-cycle strobe, bit k set on a committed write to reg k

Behaviour:
- Reset (ARESET=1 at an edge): all registers 0; state machines return to idle. AWREADY, WREADY, ARREADY, BVALID, RVALID, wr_pulse are 0. BRESP, RRESP and RDATA are 0. This applies in every state; a reset mid-transaction aborts it with no partial write and no response.
- All ready, valid and response outputs are registered. The READYs first go high after the first edge with ARESET=0.
- Index = addr >> ADDR_LSB. The address is out of range if index >= NUM_REGS. The low ADDR_LSB bits are ignored.
- Write FSM states:
  - WR_IDLE: AWREADY=1, WREADY=1.
    - AW only accepted -> WR_ADDR (latch AWADDR).
    - W only accepted -> WR_DATA (latch WDATA, WSTRB).
    - Both accepted on the same edge -> WR_RESP.
  - WR_ADDR: AWREADY=0, WREADY=1. W accepted -> WR_RESP.
  - WR_DATA: AWREADY=1, WREADY=0. AW accepted -> WR_RESP.
  - WR_RESP: AWREADY=0, WREADY=0, BVALID=1. BRESP is held stable until BVALID&&BREADY, then -> WR_IDLE.
- Write commit: on the edge where the pair completes (transition into WR_RESP), for an in-range index, each byte lane with WSTRB=1 is updated and the other lanes hold. wr_pulse[index]=1 for the following cycle only. This happens even when WSTRB=0.
- Out-of-range write: no register change, no wr_pulse, BRESP=10.
- Write latency: with AW and W on the same edge k, BVALID is high in cycle k+1. If BREADY=1, the FSM is back in WR_IDLE after edge k+1, and the next AW/W can be accepted at edge k+2.
- Read FSM states:
  - RD_IDLE: ARREADY=1. On ARVALID, RDATA and RRESP are captured from the register bank at that edge -> RD_DATA.
  - RD_DATA: ARREADY=0, RVALID=1. RDATA and RRESP are held stable until RVALID&&RREADY, then -> RD_IDLE.
- Out-of-range read returns RDATA=0 and RRESP=10.
- Read/write collision: a read accepted on the same edge as a write commit to the same register returns the pre-write value.
- Read and write FSMs never stall each other.
- reg_out reflects register state combinationally from the flops, updated the cycle after commit.

Test Plan:
1. Reset held 3 cycles, then released -> all outputs 0 during reset. AWREADY=WREADY=ARREADY=1 one cycle after release. Read of 0x0C -> RDATA=0x00000000, RRESP=00.
2. AW 0x04 and W 0xDEADBEEF/WSTRB 4'hF on the same edge, BREADY=1 -> BVALID=1 next cycle with BRESP=00. reg_out[63:32]=0xDEADBEEF. wr_pulse=8'b00000010 for exactly one cycle.
3. AW 0x04 first, W 0x11223344 with WSTRB 4'b0101 three cycles later (reg1=0xDEADBEEF) -> AWREADY=0 and WREADY=1 while waiting. reg1 becomes 0xDE22BE44 and BRESP=00.
4. BREADY held low 5 cycles after a write -> BVALID stays 1 with BRESP stable, AWREADY=WREADY=0, and a new AWVALID is not accepted until the B handshake completes.
5. Write to AWADDR 0x20 (NUM_REGS=8) -> BRESP=10, no register change, no wr_pulse. Read of ARADDR 0x40 -> RDATA=0, RRESP=10.
6. Read of reg 2 accepted on the same edge as a write commit of 0xA5A5A5A5 to reg 2 (old value 0x0) -> RDATA=0x00000000, and a subsequent read returns 0xA5A5A5A5. ARESET pulsed while in WR_RESP -> BVALID=0 the next cycle and all registers are 0.

Source files
------------

// File: rtl/axi_lite_slave_regs_if.sv
// AXI4-Lite AW/W/B/AR/R channel bundle between the team's master and a register slave.
// Pure wiring: no latency, no storage; backpressure is carried by the VALID/READY pairs.
// Flow control is entirely defined by the endpoints attached to the modports.
interface axi_lite_slave_regs_if;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] AWADDR;
    logic        WVALID;
    logic        WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        BVALID;
    logic        BREADY;
    logic [1:0]  BRESP;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] ARADDR;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;

    modport master (
        output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave backing NUM_REGS x 32-bit registers with byte strobes, SLVERR on out-of-range.
// Latency: BVALID / RVALID one cycle after the completing AW+W / AR handshake edge.
// Backpressure: one outstanding write and one outstanding read; READYs drop until B / R drain.
module axi_lite_slave_regs #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_LSB = 2
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    axi_lite_slave_regs_if.slave     s_axi,
    output logic [NUM_REGS*32-1:0]   reg_out,
    output logic [NUM_REGS-1:0]      wr_pulse
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    wr_state_t   wr_state, wr_state_nxt;
    rd_state_t   rd_state, rd_state_nxt;
    logic        aw_hs, w_hs, ar_hs, wr_commit;
    logic [31:0] awaddr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wr_addr, wr_data, wr_word_idx, rd_word_idx;
    logic [3:0]  wr_strb;
    logic        wr_in_range, rd_in_range;
    logic [31:0] regs [NUM_REGS];

    assign aw_hs = s_axi.AWVALID && s_axi.AWREADY;
    assign w_hs  = s_axi.WVALID  && s_axi.WREADY;
    assign ar_hs = s_axi.ARVALID && s_axi.ARREADY;

    // Whichever half arrived earlier comes from the latch, the other straight off the bus.
    assign wr_addr     = (wr_state == WR_ADDR) ? awaddr_q : s_axi.AWADDR;
    assign wr_data     = (wr_state == WR_DATA) ? wdata_q  : s_axi.WDATA;
    assign wr_strb     = (wr_state == WR_DATA) ? wstrb_q  : s_axi.WSTRB;
    assign wr_word_idx = wr_addr >> ADDR_LSB;
    assign wr_in_range = wr_word_idx < 32'(NUM_REGS);
    assign rd_word_idx = s_axi.ARADDR >> ADDR_LSB;
    assign rd_in_range = rd_word_idx < 32'(NUM_REGS);

    always_comb begin
        wr_state_nxt = wr_state;
        wr_commit    = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_state_nxt = WR_RESP;
                    wr_commit    = 1'b1;
                end else if (aw_hs) begin
                    wr_state_nxt = WR_ADDR;
                end else if (w_hs) begin
                    wr_state_nxt = WR_DATA;
                end
            end
            WR_ADDR: if (w_hs) begin
                wr_state_nxt = WR_RESP;
                wr_commit    = 1'b1;
            end
            WR_DATA: if (aw_hs) begin
                wr_state_nxt = WR_RESP;
                wr_commit    = 1'b1;
            end
            WR_RESP: if (s_axi.BVALID && s_axi.BREADY) wr_state_nxt = WR_IDLE;
            default: wr_state_nxt = WR_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state      <= WR_IDLE;
            s_axi.AWREADY <= 1'b0;
            s_axi.WREADY  <= 1'b0;
            s_axi.BVALID  <= 1'b0;
            s_axi.BRESP   <= RESP_OKAY;
            wr_pulse      <= '0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
        end else begin
            wr_state      <= wr_state_nxt;
            s_axi.AWREADY <= (wr_state_nxt == WR_IDLE) || (wr_state_nxt == WR_DATA);
            s_axi.WREADY  <= (wr_state_nxt == WR_IDLE) || (wr_state_nxt == WR_ADDR);
            s_axi.BVALID  <= (wr_state_nxt == WR_RESP);
            wr_pulse      <= '0;
            if (aw_hs) awaddr_q <= s_axi.AWADDR;
            if (w_hs) begin
                wdata_q <= s_axi.WDATA;
                wstrb_q <= s_axi.WSTRB;
            end
            if (wr_commit) begin
                s_axi.BRESP <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                if (wr_in_range) wr_pulse[wr_word_idx[IDX_W-1:0]] <= 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else if (wr_commit && wr_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) regs[wr_word_idx[IDX_W-1:0]][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs) rd_state_nxt = RD_DATA;
            RD_DATA: if (s_axi.RVALID && s_axi.RREADY) rd_state_nxt = RD_IDLE;
            default: rd_state_nxt = RD_IDLE;
        endcase
    end

    // Sampling regs with <= on the accept edge yields the pre-write value on a collision.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state      <= RD_IDLE;
            s_axi.ARREADY <= 1'b0;
            s_axi.RVALID  <= 1'b0;
            s_axi.RDATA   <= '0;
            s_axi.RRESP   <= RESP_OKAY;
        end else begin
            rd_state      <= rd_state_nxt;
            s_axi.ARREADY <= (rd_state_nxt == RD_IDLE);
            s_axi.RVALID  <= (rd_state_nxt == RD_DATA);
            if (ar_hs) begin
                s_axi.RDATA <= rd_in_range ? regs[rd_word_idx[IDX_W-1:0]] : 32'h0;
                s_axi.RRESP <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    always_comb begin
        reg_out = '0;
        for (int k = 0; k < NUM_REGS; k++) reg_out[32*k +: 32] = regs[k];
    end
endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Scoreboard bench for axi_lite_slave_regs: directed scenarios plus randomized traffic
// against a word-array reference model; a negedge monitor pops and compares responses.
module tb_axi_lite_slave_regs;
    localparam int NR = 8;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic [NR*32-1:0]  reg_out;
    logic [NR-1:0]     wr_pulse;

    axi_lite_slave_regs_if bus();

    axi_lite_slave_regs #(.NUM_REGS(NR), .ADDR_LSB(2)) dut (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .s_axi   (bus),
        .reg_out (reg_out),
        .wr_pulse(wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [1:0]       resp;
        logic [NR*32-1:0] snap;
    } bexp_t;

    int               checks = 0;
    int               errors = 0;
    logic [31:0]      mdl [NR];
    bexp_t            exp_b[$];
    logic [33:0]      exp_r[$];
    logic [NR-1:0]    exp_p[$];
    logic [NR-1:0]    prev_pulse = '0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=no_handshake expected=handshake", nm);
    endtask

    function automatic logic [NR*32-1:0] flat();
        logic [NR*32-1:0] v;
        for (int k = 0; k < NR; k++) v[32*k +: 32] = mdl[k];
        return v;
    endfunction

    // Reference: word index = byte address / 4; only indices below NR exist.
    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        logic [31:0] idx;
        bexp_t e;
        idx = addr / 4;
        if (idx < NR) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
            e.resp = 2'b00;
            exp_p.push_back(NR'(1) << idx);
        end else begin
            e.resp = 2'b10;
        end
        e.snap = flat();
        exp_b.push_back(e);
    endfunction

    function automatic logic [33:0] model_read(input logic [31:0] addr);
        logic [31:0] idx;
        idx = addr / 4;
        if (idx < NR) return {2'b00, mdl[idx]};
        return {2'b10, 32'h0};
    endfunction

    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (bus.BVALID) begin
                if (exp_b.size() == 0) chk("b_unexpected", bus.BVALID, 1'b0);
                else begin
                    chk("bresp", bus.BRESP, exp_b[0].resp);
                    if (bus.BREADY) begin
                        chk("reg_out_after_write", reg_out, exp_b[0].snap);
                        void'(exp_b.pop_front());
                    end
                end
            end
            if (bus.RVALID) begin
                if (exp_r.size() == 0) chk("r_unexpected", bus.RVALID, 1'b0);
                else begin
                    chk("rresp_rdata", {bus.RRESP, bus.RDATA}, exp_r[0]);
                    if (bus.RREADY) void'(exp_r.pop_front());
                end
            end
            if (wr_pulse != '0) begin
                if (prev_pulse != '0) chk("pulse_width", prev_pulse, '0);
                if (exp_p.size() == 0) chk("pulse_unexpected", wr_pulse, '0);
                else chk("wr_pulse", wr_pulse, exp_p.pop_front());
            end
        end
        prev_pulse = wr_pulse;
    end

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_hold);
        bit aw_done = 0, w_done = 0, aw_acc, w_acc;
        int cyc = 0;
        model_write(addr, data, strb);
        while (!(aw_done && w_done)) begin
            if (!aw_done && cyc >= aw_dly) begin bus.AWVALID = 1'b1; bus.AWADDR = addr; end
            if (!w_done && cyc >= w_dly) begin
                bus.WVALID = 1'b1; bus.WDATA = data; bus.WSTRB = strb;
            end
            @(negedge ACLK);
            if (aw_done) begin
                chk("wait_w_awready", bus.AWREADY, 1'b0);
                chk("wait_w_wready", bus.WREADY, 1'b1);
            end
            if (w_done) begin
                chk("wait_aw_awready", bus.AWREADY, 1'b1);
                chk("wait_aw_wready", bus.WREADY, 1'b0);
            end
            aw_acc = bus.AWVALID && bus.AWREADY;
            w_acc  = bus.WVALID && bus.WREADY;
            @(posedge ACLK); #1;
            if (aw_acc) begin aw_done = 1; bus.AWVALID = 1'b0; end
            if (w_acc)  begin w_done = 1;  bus.WVALID = 1'b0; end
            cyc++;
            if (cyc > 50) begin
                timeout("aw_w_accept");
                bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
                return;
            end
        end
        bus.BREADY = (b_hold == 0);
        if (b_hold > 0) begin bus.AWVALID = 1'b1; bus.AWADDR = 32'h0; end
        @(negedge ACLK);
        chk("b_latency", bus.BVALID, 1'b1);
        for (int i = 0; i < b_hold; i++) begin
            chk("hold_bvalid", bus.BVALID, 1'b1);
            chk("hold_awready", bus.AWREADY, 1'b0);
            chk("hold_wready", bus.WREADY, 1'b0);
            @(posedge ACLK); #1;
            if (i == b_hold - 1) begin bus.BREADY = 1'b1; bus.AWVALID = 1'b0; end
            @(negedge ACLK);
            chk("b_still_valid", bus.BVALID, 1'b1);
        end
        @(posedge ACLK); #1;
        bus.BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input int r_hold);
        bit acc;
        int cyc = 0;
        exp_r.push_back(model_read(addr));
        bus.ARVALID = 1'b1;
        bus.ARADDR  = addr;
        do begin
            @(negedge ACLK);
            acc = bus.ARVALID && bus.ARREADY;
            @(posedge ACLK); #1;
            cyc++;
        end while (!acc && cyc <= 50);
        bus.ARVALID = 1'b0;
        if (!acc) begin timeout("ar_accept"); return; end
        bus.RREADY = (r_hold == 0);
        @(negedge ACLK);
        chk("r_latency", bus.RVALID, 1'b1);
        for (int i = 0; i < r_hold; i++) begin
            chk("hold_arready", bus.ARREADY, 1'b0);
            @(posedge ACLK); #1;
            if (i == r_hold - 1) bus.RREADY = 1'b1;
            @(negedge ACLK);
            chk("r_still_valid", bus.RVALID, 1'b1);
        end
        @(posedge ACLK); #1;
        bus.RREADY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NR; k++) mdl[k] = '0;
        bus.AWVALID = 0; bus.AWADDR = 0; bus.WVALID = 0; bus.WDATA = 0; bus.WSTRB = 0;
        bus.BREADY = 0; bus.ARVALID = 0; bus.ARADDR = 0; bus.RREADY = 0;

        // Reset held for three edges; every output must sit at zero.
        repeat (3) begin
            @(posedge ACLK);
            @(negedge ACLK);
            chk("rst_handshake_outs", {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID}, 5'b0);
            chk("rst_resp_data", {bus.BRESP, bus.RRESP, bus.RDATA, wr_pulse}, '0);
            chk("rst_reg_out", reg_out, '0);
        end
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("release_ready", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
        @(posedge ACLK); #1;
        do_read(32'h0C, 0);

        do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        chk("t2_reg1", reg_out[63:32], 32'hDEADBEEF);

        do_write(32'h04, 32'h11223344, 4'b0101, 0, 3, 0);
        chk("t3_reg1", reg_out[63:32], 32'hDE22BE44);

        do_write(32'h14, 32'hCAFEF00D, 4'hF, 0, 0, 5);

        do_write(32'h20, 32'h55555555, 4'hF, 0, 0, 0);
        do_read(32'h40, 0);

        // Read of reg 2 accepted on the same edge as the write that commits to it.
        exp_r.push_back(model_read(32'h08));
        model_write(32'h08, 32'hA5A5A5A5, 4'hF);
        bus.AWVALID = 1; bus.AWADDR = 32'h08; bus.WVALID = 1; bus.WDATA = 32'hA5A5A5A5;
        bus.WSTRB = 4'hF; bus.ARVALID = 1; bus.ARADDR = 32'h08; bus.BREADY = 1; bus.RREADY = 1;
        @(negedge ACLK);
        chk("coll_ready", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
        @(posedge ACLK); #1;
        bus.AWVALID = 0; bus.WVALID = 0; bus.ARVALID = 0;
        @(negedge ACLK);
        chk("coll_rdata", bus.RDATA, 32'h0);
        @(posedge ACLK); #1;
        bus.BREADY = 0; bus.RREADY = 0;
        do_read(32'h08, 1);

        // Reset while a write response is pending.
        model_write(32'h0C, 32'h12345678, 4'hF);
        bus.AWVALID = 1; bus.AWADDR = 32'h0C; bus.WVALID = 1; bus.WDATA = 32'h12345678; bus.WSTRB = 4'hF;
        @(negedge ACLK);
        chk("rst_accept", {bus.AWREADY, bus.WREADY}, 2'b11);
        @(posedge ACLK); #1;
        bus.AWVALID = 0; bus.WVALID = 0;
        @(negedge ACLK);
        chk("rst_pre_bvalid", bus.BVALID, 1'b1);
        @(posedge ACLK); #1;
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        exp_b.delete();
        for (int k = 0; k < NR; k++) mdl[k] = '0;
        @(negedge ACLK);
        chk("rst_mid_bvalid", bus.BVALID, 1'b0);
        chk("rst_mid_regs", reg_out, '0);
        @(posedge ACLK); #1;

        for (int n = 0; n < 40; n++) begin
            int op, wi, ri;
            logic [31:0] wa, ra;
            op = $urandom_range(0, 2);
            wi = $urandom_range(0, 9);
            ri = (wi + 1 + $urandom_range(0, 7)) % 10;
            wa = (32'(wi) << 2) | 32'($urandom_range(0, 3));
            ra = (32'(ri) << 2) | 32'($urandom_range(0, 3));
            if (op == 0) begin
                do_write(wa, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 2));
            end else if (op == 1) begin
                do_read(ra, $urandom_range(0, 2));
            end else begin
                fork
                    do_write(wa, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                             $urandom_range(0, 2), $urandom_range(0, 2));
                    do_read(ra, $urandom_range(0, 2));
                join
            end
        end

        repeat (4) @(posedge ACLK);
        @(negedge ACLK);
        chk("b_drain", exp_b.size(), 0);
        chk("r_drain", exp_r.size(), 0);
        chk("pulse_drain", exp_p.size(), 0);
        chk("final_reg_out", reg_out, flat());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
